// File: rtl/tpu_pkg.sv
// tpu_pkg: widths shared across the array datapath and the activation feeder state encoding.
package tpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  typedef enum logic [2:0] {IDLE, FETCH, RDWAIT, STREAM, FLUSH, DONE} feeder_state_e;
endpackage

// File: rtl/feeder_row_buffer.sv
// feeder_row_buffer: 2 x MAX_K activation register file, one write port, two combinational lane reads.
module feeder_row_buffer
  import tpu_pkg::*;
#(
  parameter int MAX_K = 4,
  parameter int CLW   = MAX_K > 1 ? $clog2(MAX_K) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              wr_row_i,
  input  logic [CLW-1:0]    wr_col_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [CLW-1:0]    rd_col0_i,
  input  logic [CLW-1:0]    rd_col1_i,
  output logic [DATA_W-1:0] rd_data0_o,
  output logic [DATA_W-1:0] rd_data1_o
);
  logic [DATA_W-1:0] mem_q [2][MAX_K];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[wr_row_i][wr_col_i] <= wr_data_i;
  assign rd_data0_o = mem_q[0][rd_col0_i];
  assign rd_data1_o = mem_q[1][rd_col1_i];
endmodule

// File: rtl/ub_activation_feeder.sv
// ub_activation_feeder: fetches a 2xK activation tile from the unified buffer and streams it skewed into the array.
module ub_activation_feeder
  import tpu_pkg::*;
#(
  parameter int MAX_K        = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [2:0]        num_cols_i,
  output logic              ub_rd_en_o,
  output logic [ADDR_W-1:0] ub_rd_addr_o,
  input  logic [DATA_W-1:0] ub_rd_data_i,
  output logic [DATA_W-1:0] a_in1_o,
  output logic [DATA_W-1:0] a_in2_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int CLW = MAX_K > 1 ? $clog2(MAX_K) : 1;
  feeder_state_e     state_q;
  logic [2:0]        k_q, kc_d;
  logic [7:0]        cnt_q, widx_q, k_d, s_d, wcol_d, last_rd_d;
  logic              pend_q, wrow_d, rd_en_q, valid_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] a1_q, a2_q, rd0, rd1;
  always_comb begin
    kc_d      = num_cols_i > 3'(MAX_K) ? 3'(MAX_K) : num_cols_i;
    k_d       = 8'(k_q);
    last_rd_d = (k_d << 1) - 8'd1;
    s_d       = state_q == STREAM ? cnt_q + 8'd1 : 8'd0;
    wrow_d    = widx_q >= k_d;
    wcol_d    = wrow_d ? widx_q - k_d : widx_q;
  end
  feeder_row_buffer #(.MAX_K(MAX_K)) u_buf (
    .clk_i     (clk_i),
    .we_i      (pend_q),
    .wr_row_i  (wrow_d),
    .wr_col_i  (CLW'(wcol_d)),
    .wr_data_i (ub_rd_data_i),
    .rd_col0_i (CLW'(s_d)),
    .rd_col1_i (CLW'(s_d - 8'd1)),
    .rd_data0_o(rd0),
    .rd_data1_o(rd1)
  );
  // Read data lands one cycle after the strobe, so the write side trails the read side by pend_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
    end else begin
      pend_q <= rd_en_q;
      if (pend_q) widx_q <= widx_q + 8'd1;
      case (state_q)
        IDLE: if (start_i) begin
          k_q     <= kc_d;
          addr_q  <= base_addr_i;
          cnt_q   <= '0;
          widx_q  <= '0;
          state_q <= kc_d == 3'd0 ? DONE : FETCH;
          done_q  <= kc_d == 3'd0;
          rd_en_q <= kc_d != 3'd0;
          busy_q  <= kc_d != 3'd0;
        end
        FETCH: if (cnt_q == last_rd_d) begin
          state_q <= RDWAIT;
          rd_en_q <= 1'b0;
        end else begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q + 8'd1;
        end
        RDWAIT, STREAM: if (state_q == STREAM && cnt_q == k_d) begin
          state_q <= FLUSH;
          cnt_q   <= '0;
          a1_q    <= '0;
          a2_q    <= '0;
        end else begin
          state_q <= STREAM;
          valid_q <= 1'b1;
          cnt_q   <= s_d;
          a1_q    <= s_d < k_d ? rd0 : '0;
          a2_q    <= s_d != 8'd0 ? rd1 : '0;
        end
        FLUSH: if (cnt_q == 8'(FLUSH_CYCLES - 1)) begin
          state_q <= DONE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign ub_rd_en_o   = rd_en_q;
  assign ub_rd_addr_o = addr_q;
  assign a_in1_o      = a1_q;
  assign a_in2_o      = a2_q;
  assign valid_o      = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
endmodule

// File: doc/ub_activation_feeder.md
Name: ub_activation_feeder

Overview:
- Reads a 2xK activation matrix from the unified buffer and streams it into the 2x2 systolic array's left edge (a_in1/a_in2 plus valid).
- Applies the diagonal skew: lane 1 lags lane 0 by one cycle. It then holds valid for a zero-filled flush so the accumulators drain.
- It is the read-side counterpart to the accumulator-to-unified-buffer write path, and replaces hand-skewed stimulus.

Parameters:
- DATA_W, 16, activation word width (matches a_in1/a_in2).
- ADDR_W, 4, unified buffer address width.
- MAX_K, 4, maximum columns per row held in the local row buffer.
- FLUSH_CYCLES, 4, extra valid cycles with zero activations after the last real element.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  ADDR_W  unified buffer address of A[0][0]. Layout is row-major: A[r][k] at base_addr + r*K + k.
- num_cols  in  3  K, columns per row; sampled with start.
- ub_rd_en  out  1  unified buffer read strobe.
- ub_rd_addr  out  ADDR_W  unified buffer read address.
- ub_rd_data  in  DATA_W  read data, valid exactly one cycle after ub_rd_en.
- a_in1  out  DATA_W  activation into array row 0.
- a_in2  out  DATA_W  activation into array row 1.
- valid  out  1  array valid strobe.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. The row buffer is not cleared. Reset mid-transfer aborts immediately: no further reads, valid=0 next cycle, done not pulsed.
- States: IDLE -> FETCH -> RDWAIT -> STREAM -> FLUSH -> DONE -> IDLE.
- IDLE:
  - start=1 latches base_addr and K = min(num_cols, MAX_K).
  - K=0 goes straight to DONE: no reads, no valid.
- FETCH:
  - Runs 2K cycles with ub_rd_en=1 and ub_rd_addr = base + i for i = 0..2K-1.
  - Address wraps modulo 2^ADDR_W.
  - Data returned in the following cycle is written to buf[i/K][i%K].
- RDWAIT: one cycle; captures the final word; ub_rd_en=0.
- STREAM: K+1 cycles, s = 0..K, valid=1.
  - a_in1 = buf[0][s] when s<K, otherwise 0.
  - a_in2 = buf[1][s-1] when s>=1, otherwise 0.
- FLUSH: FLUSH_CYCLES cycles with valid=1 and a_in1=a_in2=0.
- DONE: done=1 for one cycle; valid=0; busy=0; return to IDLE.
- Outputs: all registered.
  - With start accepted on the edge ending cycle T, valid is first high in cycle T+2K+2.
  - valid then stays high for exactly K+1+FLUSH_CYCLES consecutive cycles.
  - done is high in the cycle right after the last valid.
- No data width conversion; activations pass through unchanged.
- start while not IDLE is ignored, including start coincident with done. A new start is accepted in the cycle after done.
- ub_rd_en is never high outside FETCH.

Decomposition:
- tpu_pkg holds DATA_W, ADDR_W, and the feeder state enum (IDLE, FETCH, RDWAIT, STREAM, FLUSH, DONE). The systolic array and accumulators share DATA_W from it.
- One natural sub-module: feeder_row_buffer, a 2xMAX_K register file with a write port (row, col, data, we) and two combinational read ports (lane0 col, lane1 col).
- The FSM, counters and skew muxing stay in ub_activation_feeder.

Test Plan:
- Basic 2x2: UB[0..3] = 11, 12, 21, 22; base=0, K=2, FLUSH=4; start.
  - Reads at addresses 0, 1, 2, 3 in four consecutive cycles.
  - Then, over 7 valid cycles: a_in1 = 11, 12, 0, 0, 0, 0, 0 and a_in2 = 0, 21, 22, 0, 0, 0, 0.
  - done in the next cycle.
- Address wrap: base=14, K=2, ADDR_W=4, data 1, 2, 3, 4 at addresses 14, 15, 0, 1.
  - ub_rd_addr sequence is 14, 15, 0, 1.
  - a_in1 = 1, 2, 0... and a_in2 = 0, 3, 4, 0...
- K=0 and K>MAX_K:
  - num_cols=0: done one cycle after start, with no ub_rd_en and no valid.
  - num_cols=7: clamped to 4, giving 8 reads and 9 valid cycles.
- start while busy: pulse start during STREAM with a different base.
  - The stream is unchanged and there is no second transfer.
  - A start in the cycle after done is accepted.
- Reset mid-STREAM: assert reset for 1 cycle after the 2nd valid cycle.
  - Next cycle: valid=0, a_in1=a_in2=0, busy=0, no done pulse.
  - A subsequent start with K=1 and data 9, 8 gives a_in1 = 9, 0... and a_in2 = 0, 8, 0....
- Back-to-back: two transfers with K=1 then K=3, started the cycle after each done.
  - Latency T+2K+2 and valid length K+1+FLUSH hold for both.
